// File: rtl/mem_responder.sv
// Byte-addressed memory target with a fixed-latency, four-phase request/ack handshake.
// Define BIG_ENDIAN_EN to map the byte at addr onto the most significant active lane.
module mem_responder #(
   parameter int DATA_L    = 32,
   parameter int MADDR_L   = 32,
   parameter int MEM_DEPTH = 8192,
   parameter int LATENCY   = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               re,
   input  logic               we,
   input  logic [MADDR_L-1:0] addr,
   input  logic [1:0]         len,
   input  logic [DATA_L-1:0]  wdata,
   output logic [DATA_L-1:0]  rdata,
   output logic               ack,
   output logic               busy,
   output logic               err
);

   // state  | meaning
   // IDLE   | waiting for re/we, request fields captured on accept
   // WAIT   | latency down-counter running, terminal count 0 enters RESP
   // RESP   | one-cycle ack; rdata/err valid; write committed on entry
   // HOLD   | waiting for requester to drop re and we
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;
   localparam logic [1:0] S_HOLD = 2'd3;

   localparam int AW    = $clog2(MEM_DEPTH);
   localparam int WORDS = MEM_DEPTH / 4;
   localparam int CNT_W = $clog2(LATENCY + 1);
   localparam int EW    = MADDR_L + 1;

   logic [1:0]        r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [AW-1:0]     r_addr;
   logic [1:0]        r_len;
   logic [31:0]       r_wdata;
   logic              r_we_op;
   logic              r_err_q;
   logic [31:0]       r_rdata;
   logic              r_ack;
   logic              r_busy;
   logic              r_err;

   logic [31:0]       r_mem [WORDS];

   logic              w_len_bad;
   logic              w_misalign;
   logic [EW-1:0]     w_end;
   logic              w_oob;
   logic              w_req_err;
   logic [AW-3:0]     w_widx;
   logic [31:0]       w_word;
   logic [31:0]       w_rd_data;
   logic [3:0]        w_be;
   logic [31:0]       w_wd;
   logic              w_done;
   logic              w_commit;

   // Request checks are evaluated on the live inputs and latched at accept.
   assign w_len_bad  = (len == 2'd2);
   assign w_misalign = ((len == 2'd1) && addr[0]) ||
                       ((len == 2'd3) && (addr[1:0] != 2'b00));
   assign w_end      = {1'b0, addr} + EW'(len);
   assign w_oob      = (w_end >= EW'(MEM_DEPTH));
   assign w_req_err  = w_len_bad | w_misalign | w_oob | (re & we);

   assign w_widx = r_addr[AW-1:2];
   assign w_word = r_mem[w_widx];

   // Accepted accesses never straddle a word, so lanes stay within one memory word.
   always_comb begin
      logic [1:0] v_lane;
      logic [1:0] v_byte;
      w_rd_data = '0;
      v_lane    = '0;
      v_byte    = '0;
      for (int k = 0; k < 4; k++) begin
         v_lane = r_addr[1:0] + 2'(k);
`ifdef BIG_ENDIAN_EN
         v_byte = r_len - 2'(k);
`else
         v_byte = 2'(k);
`endif
         if (2'(k) <= r_len) begin
            w_rd_data[8*v_byte +: 8] = w_word[8*v_lane +: 8];
         end
      end
   end

   always_comb begin
      logic [1:0] v_lane;
      logic [1:0] v_byte;
      w_be   = '0;
      w_wd   = '0;
      v_lane = '0;
      v_byte = '0;
      for (int k = 0; k < 4; k++) begin
         v_lane = r_addr[1:0] + 2'(k);
`ifdef BIG_ENDIAN_EN
         v_byte = r_len - 2'(k);
`else
         v_byte = 2'(k);
`endif
         if (2'(k) <= r_len) begin
            w_be[v_lane]          = 1'b1;
            w_wd[8*v_lane +: 8]   = r_wdata[8*v_byte +: 8];
         end
      end
   end

   assign w_done   = (r_state == S_WAIT) && (r_cnt == '0);
   assign w_commit = w_done && r_we_op && !r_err_q;

   // Array has no reset; a reset during WAIT returns to IDLE so the write never lands.
   always_ff @(posedge clk) begin
      if (w_commit) begin
         for (int b = 0; b < 4; b++) begin
            if (w_be[b]) begin
               r_mem[w_widx][8*b +: 8] <= w_wd[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_addr  <= '0;
         r_len   <= '0;
         r_wdata <= '0;
         r_we_op <= 1'b0;
         r_err_q <= 1'b0;
         r_rdata <= '0;
         r_ack   <= 1'b0;
         r_busy  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (re | we) begin
                  r_addr  <= addr[AW-1:0];
                  r_len   <= len;
                  r_wdata <= wdata;
                  r_we_op <= we;
                  r_err_q <= w_req_err;
                  r_busy  <= 1'b1;
                  r_cnt   <= CNT_W'(LATENCY - 1);
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (r_cnt == '0) begin
                  r_state <= S_RESP;
                  r_ack   <= 1'b1;
                  r_err   <= r_err_q;
                  r_rdata <= (r_err_q || r_we_op) ? 32'd0 : w_rd_data;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            S_RESP: begin
               r_ack   <= 1'b0;
               r_state <= S_HOLD;
            end
            S_HOLD: begin
               if (!re && !we) begin
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign rdata = r_rdata;
   assign ack   = r_ack;
   assign busy  = r_busy;
   assign err   = r_err;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus randomized
// traffic compared against a byte-array reference model.
module tb_mem_responder;
   localparam int LAT   = 2;
   localparam int DEPTH = 8192;

   logic        clk;
   logic        rst;
   logic        re;
   logic        we;
   logic [31:0] addr;
   logic [1:0]  len;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ack;
   logic        busy;
   logic        err;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] mm [DEPTH];
   bit         kn [DEPTH];

   mem_responder #(
      .DATA_L(32), .MADDR_L(32), .MEM_DEPTH(DEPTH), .LATENCY(LAT)
   ) dut (
      .clk(clk), .rst(rst), .re(re), .we(we), .addr(addr), .len(len),
      .wdata(wdata), .rdata(rdata), .ack(ack), .busy(busy), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic bit model_err(input bit rd, input bit wr, input logic [31:0] a,
                                    input logic [1:0] l);
      longint last;
      last = longint'(a) + longint'(l);
      return (l == 2'd2) || (l == 2'd1 && a[0]) || (l == 2'd3 && a[1:0] != 2'b00) ||
             (last >= DEPTH) || (rd && wr);
   endfunction

   function automatic bit model_known(input logic [31:0] a, input logic [1:0] l);
      for (int k = 0; k <= int'(l); k++) if (!kn[int'(a) + k]) return 0;
      return 1;
   endfunction

   // Byte i of an access lives at address a+i; its lane position depends on endianness.
   function automatic int lane_of(input int k, input logic [1:0] l);
`ifdef BIG_ENDIAN_EN
      return int'(l) - k;
`else
      return k;
`endif
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] a, input logic [1:0] l);
      logic [31:0] v;
      v = 0;
      for (int k = 0; k <= int'(l); k++) v = v | (32'(mm[int'(a) + k]) << (8 * lane_of(k, l)));
      return v;
   endfunction

   task automatic model_write(input logic [31:0] a, input logic [1:0] l, input logic [31:0] d);
      for (int k = 0; k <= int'(l); k++) begin
         mm[int'(a) + k] = 8'((d >> (8 * lane_of(k, l))) & 32'hFF);
         kn[int'(a) + k] = 1'b1;
      end
   endtask

   task automatic do_req(input bit rd, input bit wr, input logic [31:0] a, input logic [1:0] l,
                         input logic [31:0] wd, input int hold,
                         output logic [31:0] rdo, output logic ero);
      int  k;
      bit  seen;
      @(negedge clk);
      re = rd; we = wr; addr = a; len = l; wdata = wd;
      @(negedge clk);
      chk("busy_accept", 32'(busy), 1);
      addr  = $urandom;
      wdata = $urandom;
      seen = 0; rdo = 0; ero = 0;
      for (k = 0; k <= 20; k++) begin
         if (k > 0) @(negedge clk);
         if (ack) begin
            seen = 1;
            break;
         end
      end
      if (!seen) begin
         chk("ack_timeout", 0, 1);
         re = 0; we = 0;
         return;
      end
      chk("ack_latency", 32'(k), 32'(LAT));
      rdo = rdata;
      ero = err;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk("hold_ack", 32'(ack), 0);
         chk("hold_busy", 32'(busy), 1);
      end
      re = 0; we = 0;
      @(negedge clk);
      chk("ack_pulse", 32'(ack), 0);
      if (hold > 0) begin
         chk("busy_drop", 32'(busy), 0);
      end else begin
         for (int t = 0; t < 3 && busy; t++) @(negedge clk);
         chk("busy_idle", 32'(busy), 0);
      end
   endtask

   task automatic xact(input string tag, input bit rd, input bit wr, input logic [31:0] a,
                       input logic [1:0] l, input logic [31:0] wd, input int hold);
      logic [31:0] rdo;
      logic        ero;
      bit          e;
      do_req(rd, wr, a, l, wd, hold, rdo, ero);
      e = model_err(rd, wr, a, l);
      chk({tag, "_err"}, 32'(ero), 32'(e));
      if (e) chk({tag, "_rdata_zero"}, rdo, 0);
      else if (wr) model_write(a, l, wd);
      else if (model_known(a, l)) chk({tag, "_rdata"}, rdo, model_read(a, l));
   endtask

   initial begin
      logic [31:0] rdo;
      logic        ero;
      logic [31:0] ra;
      logic [1:0]  rl;
      int          sel;
      int          p;

      for (int i = 0; i < DEPTH; i++) kn[i] = 1'b0;
      rst = 1'b1; re = 0; we = 0; addr = 0; len = 0; wdata = 0;
      repeat (2) @(negedge clk);
      chk("rst_ack", 32'(ack), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_rdata", rdata, 0);
      rst = 1'b0;

      xact("s1_wr", 0, 1, 32'h100, 2'd3, 32'hDEADBEEF, 0);
      do_req(1, 0, 32'h100, 2'd3, 0, 0, rdo, ero);
      chk("s1_rd", rdo, 32'hDEADBEEF);
      chk("s1_rd_err", 32'(ero), 0);

`ifndef BIG_ENDIAN_EN
      do_req(1, 0, 32'h101, 2'd0, 0, 0, rdo, ero);
      chk("s2_byte", rdo, 32'h000000BE);
      do_req(1, 0, 32'h102, 2'd1, 0, 0, rdo, ero);
      chk("s2_half", rdo, 32'h0000DEAD);
`endif

      xact("s3_misalign", 1, 0, 32'h102, 2'd3, 0, 0);
      xact("s3_len2", 1, 0, 32'h100, 2'd2, 0, 0);
      xact("s3_pre", 0, 1, 32'h1FFC, 2'd3, 32'hA5A5A5A5, 0);
      xact("s3_oob_wr", 0, 1, 32'h1FFE, 2'd3, 32'h0BADF00D, 0);
      do_req(1, 0, 32'h1FFC, 2'd3, 0, 0, rdo, ero);
      chk("s3_unchanged", rdo, 32'hA5A5A5A5);
      xact("s3_last_byte", 1, 0, 32'h1FFF, 2'd0, 0, 0);
      xact("s3_last_half", 1, 0, 32'h1FFE, 2'd1, 0, 0);
      xact("s3_wrap", 1, 0, 32'hFFFFFFFF, 2'd0, 0, 0);
      xact("s3_both", 1, 1, 32'h100, 2'd3, 32'h0, 0);

      xact("s4_hold", 1, 0, 32'h100, 2'd3, 0, 5);
      xact("s4_next", 1, 0, 32'h100, 2'd1, 0, 0);

      xact("s5_pre", 0, 1, 32'h200, 2'd3, 32'hCAFEF00D, 0);
      @(negedge clk);
      we = 1; re = 0; addr = 32'h200; len = 2'd3; wdata = 32'h12345678;
      @(negedge clk);
      chk("s5_busy_wait", 32'(busy), 1);
      #1 rst = 1'b1; we = 0;
      #1;
      chk("s5_rst_busy", 32'(busy), 0);
      chk("s5_rst_ack", 32'(ack), 0);
      chk("s5_rst_err", 32'(err), 0);
      chk("s5_rst_rdata", rdata, 0);
      @(negedge clk);
      rst = 1'b0;
      do_req(1, 0, 32'h200, 2'd3, 0, 0, rdo, ero);
      chk("s5_prior", rdo, 32'hCAFEF00D);

`ifdef BIG_ENDIAN_EN
      xact("s6_wr", 0, 1, 32'h0, 2'd3, 32'h11223344, 0);
      do_req(1, 0, 32'h0, 2'd0, 0, 0, rdo, ero);
      chk("s6_be_byte", rdo, 32'h00000011);
`endif

      for (int i = 0; i < 16; i++) xact("init", 0, 1, 32'(4 * i), 2'd3, $urandom, 0);
      for (int i = 0; i < 60; i++) begin
         sel = $urandom_range(0, 9);
         if (sel <= 6)      ra = 32'($urandom_range(0, 63));
         else if (sel == 7) ra = 32'h1FF8 + 32'($urandom_range(0, 7));
         else if (sel == 8) ra = 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
         else               ra = 32'h100 + 32'($urandom_range(0, 7));
         rl = 2'($urandom_range(0, 3));
         p  = $urandom_range(0, 19);
         if (p < 10)      xact("rnd_rd", 1, 0, ra, rl, 0, $urandom_range(0, 2));
         else if (p < 18) xact("rnd_wr", 0, 1, ra, rl, $urandom, $urandom_range(0, 2));
         else             xact("rnd_both", 1, 1, ra, rl, $urandom, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
